// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem initiator feeding a 2-entry
// prefetch FIFO whose head drives the Decoder-facing pc/instruction/pc_next.
module fetch_unit #(
    parameter int unsigned ADDRESS_BITS = 32,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [ADDRESS_BITS-1:0] imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [31:0]             imem_rdata,
    input  logic                    pc_s_d,
    input  logic [ADDRESS_BITS-1:0] target_pc,
    input  logic                    stall,
    output logic                    valid,
    output logic [ADDRESS_BITS-1:0] pc,
    output logic [31:0]             instruction,
    output logic [ADDRESS_BITS-1:0] pc_next
);

    localparam int unsigned AB    = ADDRESS_BITS;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [AB-1:0] PC_STEP       = AB'(4);
    localparam logic [AB-1:0] ALIGN_MASK    = ~AB'(3);
    localparam logic [AB-1:0] RESET_PC_NEXT = RESET_PC + PC_STEP;
    localparam logic [IW-1:0] NOP           = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AB-1:0] fetch_pc_q, fetch_pc_d;
    logic [AB-1:0] req_pc_q, req_pc_d;
    logic          outstanding_q, outstanding_d;
    logic [1:0]    count_q, count_d;
    logic          push, pop, wr_slot;

    logic [AB-1:0] ent_pc_q      [DEPTH];
    logic [AB-1:0] ent_pc_next_q [DEPTH];
    logic [IW-1:0] ent_instr_q   [DEPTH];

    assign valid       = (count_q != 2'd0);
    assign pc          = ent_pc_q[0];
    assign pc_next     = ent_pc_next_q[0];
    assign instruction = ent_instr_q[0];
    assign imem_addr   = fetch_pc_q;

    // Redirect squashes any consume of the head in the same cycle.
    assign pop     = valid && !stall && !pc_s_d;
    assign wr_slot = (count_q == 2'd1) && !pop;

    // Next-state, request generation and FIFO occupancy.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        push          = 1'b0;
        imem_req      = 1'b0;

        unique case (state_q)
            ST_REQ: begin
                imem_req = !rst && ((3'(count_q) + 3'(outstanding_q)) < 3'd2);
                if (imem_req && imem_gnt) begin
                    fetch_pc_d    = fetch_pc_q + PC_STEP;
                    req_pc_d      = fetch_pc_q;
                    outstanding_d = 1'b1;
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    push          = 1'b1;
                    outstanding_d = 1'b0;
                    state_d       = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    outstanding_d = 1'b0;
                    state_d       = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // A request still in flight after a redirect must have its data discarded.
        if (pc_s_d) begin
            fetch_pc_d = target_pc & ALIGN_MASK;
            push       = 1'b0;
            if (state_d == ST_WAIT) begin
                state_d = ST_DROP;
            end
        end

        if (pc_s_d) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_REQ;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            count_q       <= 2'd0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_pc_q[i]      <= RESET_PC;
                ent_pc_next_q[i] <= RESET_PC_NEXT;
                ent_instr_q[i]   <= NOP;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            if (pop && (count_q == 2'd2)) begin
                ent_pc_q[0]      <= ent_pc_q[1];
                ent_pc_next_q[0] <= ent_pc_next_q[1];
                ent_instr_q[0]   <= ent_instr_q[1];
            end
            // Push lands in the slot that is free after this cycle's pop.
            if (push) begin
                if (wr_slot) begin
                    ent_pc_q[1]      <= req_pc_q;
                    ent_pc_next_q[1] <= req_pc_q + PC_STEP;
                    ent_instr_q[1]   <= imem_rdata;
                end else begin
                    ent_pc_q[0]      <= req_pc_q;
                    ent_pc_next_q[0] <= req_pc_q + PC_STEP;
                    ent_instr_q[0]   <= imem_rdata;
                end
            end
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == 2'd2)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table for boot/stream/stall,
// plus hand sequences for redirect, simultaneous-event and wrap corners.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        pc_s_d;
    logic [31:0] target_pc;
    logic        stall;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] pc_next;

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory model: grants when enabled, answers lat cycles after the grant.
    logic        gnt_en = 1'b1;
    int          lat    = 2;
    int          mcnt   = 0;
    logic [31:0] maddr  = '0;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_s_d      (pc_s_d),
        .target_pc   (target_pc),
        .stall       (stall),
        .valid       (valid),
        .pc          (pc),
        .instruction (instruction),
        .pc_next     (pc_next)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0070_8093;
            32'h4:   return 32'h0031_0113;
            32'h8:   return 32'h00A0_0193;
            default: return a ^ 32'h1357_0013;
        endcase
    endfunction

    assign imem_gnt    = imem_req && gnt_en;
    assign imem_rvalid = (mcnt == 1);
    assign imem_rdata  = memword(maddr);

    always @(posedge clk) begin
        if (mcnt != 0) mcnt <= mcnt - 1;
        if (imem_req && imem_gnt) begin
            mcnt  <= lat;
            maddr <= imem_addr;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive inputs for the current cycle, then settle to the sampling point.
    task automatic drive(input logic r, input logic s, input logic j, input logic [31:0] t);
        rst       = r;
        stall     = s;
        pc_s_d    = j;
        target_pc = t;
        @(negedge clk);
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(1'b1, 1'b0, 1'b0, 32'h0); adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0); adv();
    endtask

    typedef struct {
        logic        rst, stall, pcsd;
        logic [31:0] tgt;
        logic        chk_en;
        logic        valid;
        logic [31:0] pc, instr;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic c,
                                input logic v, input logic [31:0] p, input logic [31:0] i,
                                input logic q, input logic [31:0] a);
        vec_t x;
        x.rst = r; x.stall = s; x.pcsd = 1'b0; x.tgt = '0; x.chk_en = c;
        x.valid = v; x.pc = p; x.instr = i; x.req = q; x.addr = a;
        return x;
    endfunction

    vec_t vecs[$];

    initial begin
        rst = 1'b1; stall = 1'b0; pc_s_d = 1'b0; target_pc = '0;
        #1;

        // Boot, 2-cycle-latency stream, then stall backpressure and release.
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,  32'h0,          0, 32'h0));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,  32'h0000_0013,  0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,  32'h0,          1, 32'h0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,  32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,  32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h0,  32'h0070_8093,  1, 32'h4));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,  32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,  32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h4,  32'h0031_0113,  1, 32'h8));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,  32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,  32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h8,  32'h00A0_0193,  1, 32'hC));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,  32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,  32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'hC,  32'h1357_001F,  1, 32'h10));
        vecs.push_back(mk(0, 1, 1, 1, 32'hC,  32'h1357_001F,  0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'hC,  32'h1357_001F,  0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'hC,  32'h1357_001F,  0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'hC,  32'h1357_001F,  0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 1, 32'hC,  32'h1357_001F,  0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h10, 32'h1357_0003,  1, 32'h14));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,  32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,  32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h14, 32'h1357_0007,  1, 32'h18));

        lat = 2; gnt_en = 1'b1;
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].stall, vecs[k].pcsd, vecs[k].tgt);
            if (vecs[k].chk_en) begin
                chk($sformatf("vec%0d valid", k), 32'(valid), 32'(vecs[k].valid));
                chk($sformatf("vec%0d req", k), 32'(imem_req), 32'(vecs[k].req));
                if (vecs[k].req)
                    chk($sformatf("vec%0d addr", k), imem_addr, vecs[k].addr);
                if (vecs[k].valid || vecs[k].rst) begin
                    chk($sformatf("vec%0d pc", k), pc, vecs[k].pc);
                    chk($sformatf("vec%0d instr", k), instruction, vecs[k].instr);
                    chk($sformatf("vec%0d pc_next", k), pc_next, vecs[k].pc + 32'd4);
                end
            end
            adv();
        end

        // Idle redirect to 0x10, grant it, then redirect to 0x60 while waiting.
        lat = 2; gnt_en = 1'b1;
        do_reset();
        gnt_en = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'h10); adv();
        gnt_en = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rdw n1 req", 32'(imem_req), 32'h1);
        chk("rdw n1 addr", imem_addr, 32'h10);
        chk("rdw n1 valid", 32'(valid), 32'h0);
        adv();
        drive(1'b0, 1'b0, 1'b1, 32'h60);
        chk("rdw n2 valid", 32'(valid), 32'h0);
        adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rdw n3 req", 32'(imem_req), 32'h0);
        chk("rdw n3 valid", 32'(valid), 32'h0);
        adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rdw n4 req", 32'(imem_req), 32'h1);
        chk("rdw n4 addr", imem_addr, 32'h60);
        chk("rdw n4 valid", 32'(valid), 32'h0);
        adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rdw n5 valid", 32'(valid), 32'h0);
        adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rdw n6 valid", 32'(valid), 32'h0);
        adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rdw n7 valid", 32'(valid), 32'h1);
        chk("rdw n7 pc", pc, 32'h60);
        chk("rdw n7 instr", instruction, 32'h1357_0073);
        adv();

        // Redirect coinciding with rvalid and a consume, unaligned target.
        lat = 1; gnt_en = 1'b1;
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0); adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0); adv();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk("sim r2 valid", 32'(valid), 32'h1);
        chk("sim r2 pc", pc, 32'h0);
        chk("sim r2 addr", imem_addr, 32'h4);
        adv();
        drive(1'b0, 1'b0, 1'b1, 32'h52);
        chk("sim r3 rvalid", 32'(imem_rvalid), 32'h1);
        chk("sim r3 valid", 32'(valid), 32'h1);
        adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("sim r4 valid", 32'(valid), 32'h0);
        chk("sim r4 req", 32'(imem_req), 32'h1);
        chk("sim r4 addr", imem_addr, 32'h50);
        adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("sim r5 valid", 32'(valid), 32'h0);
        adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("sim r6 valid", 32'(valid), 32'h1);
        chk("sim r6 pc", pc, 32'h50);
        chk("sim r6 instr", instruction, 32'h1357_0043);
        chk("sim r6 pc_next", pc_next, 32'h54);
        adv();

        // Address wrap at the top of the space.
        lat = 1; gnt_en = 1'b1;
        do_reset();
        gnt_en = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC); adv();
        gnt_en = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap n1 addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap n1 valid", 32'(valid), 32'h0);
        adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap n2 valid", 32'(valid), 32'h0);
        adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap n3 valid", 32'(valid), 32'h1);
        chk("wrap n3 pc", pc, 32'hFFFF_FFFC);
        chk("wrap n3 pc_next", pc_next, 32'h0);
        chk("wrap n3 instr", instruction, 32'hECA8_FFEF);
        chk("wrap n3 req", 32'(imem_req), 32'h1);
        chk("wrap n3 addr", imem_addr, 32'h0);
        adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0); adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap n5 valid", 32'(valid), 32'h1);
        chk("wrap n5 pc", pc, 32'h0);
        chk("wrap n5 instr", instruction, 32'h0070_8093);
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
